// File: rtl/game_minute_clock.sv
// Game-minute clock: prescaled minute counter with hold/saturate control and a quiz deadline.
// Optional BCD mirror of the minute count is enabled by defining GAME_MINUTE_CLOCK_BCD_EN.
module game_minute_clock #(
  parameter int unsigned TICKS_PER_MIN = 100_000_000,
  parameter logic [7:0]  MAX_MIN       = 8'd255,
  parameter logic [7:0]  QUIZ_WIN      = 8'd3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic        hold_i,
  input  logic        arm_i,
  input  logic        disarm_i,
  output logic [7:0]  minutes_o,
  output logic        min_tick_o,
  output logic        running_o,
  output logic        saturated_o,
  output logic        deadline_hit_o
`ifdef GAME_MINUTE_CLOCK_BCD_EN
  ,
  output logic [11:0] minutes_bcd_o
`endif
);

  localparam int unsigned         PRE_W  = $clog2(TICKS_PER_MIN);
  localparam logic [PRE_W-1:0]    PRE_TC = PRE_W'(TICKS_PER_MIN - 1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_SAT  = 2'd3
  } state_e;

  state_e           state_q;
  logic [PRE_W-1:0] presc_q;
  logic [7:0]       minutes_q;
  logic [7:0]       minutes_inc;
  logic [7:0]       deadline_q;
  logic [7:0]       deadline_d;
  logic [8:0]       deadline_sum;
  logic             armed_q;
  logic             min_tick_q;
  logic             presc_tc;

  assign presc_tc    = (presc_q == PRE_TC);
  assign minutes_inc = minutes_q + 8'd1;

  // Deadline sum is widened so minutes near 255 cannot wrap before the clamp.
  assign deadline_sum = {1'b0, minutes_q} + {1'b0, QUIZ_WIN};
  assign deadline_d   = (deadline_sum > {1'b0, MAX_MIN}) ? MAX_MIN : deadline_sum[7:0];

`ifdef GAME_MINUTE_CLOCK_BCD_EN
  logic [11:0] bcd_q;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == 4'd9) begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_STOP;
      presc_q    <= '0;
      minutes_q  <= 8'd0;
      deadline_q <= 8'd0;
      armed_q    <= 1'b0;
      min_tick_q <= 1'b0;
`ifdef GAME_MINUTE_CLOCK_BCD_EN
      bcd_q      <= 12'h000;
`endif
    end else if (clear_i) begin
      state_q    <= ST_STOP;
      presc_q    <= '0;
      minutes_q  <= 8'd0;
      deadline_q <= 8'd0;
      armed_q    <= 1'b0;
      min_tick_q <= 1'b0;
`ifdef GAME_MINUTE_CLOCK_BCD_EN
      bcd_q      <= 12'h000;
`endif
    end else begin
      min_tick_q <= 1'b0;
      case (state_q)
        ST_STOP: begin
          presc_q   <= '0;
          minutes_q <= 8'd0;
          if (start_i && !hold_i) begin
            state_q <= ST_RUN;
          end
        end
        // Hold outranks the terminal count, so the prescaler parks at terminal
        // and the pending increment fires on the first RUN cycle after release.
        ST_RUN: begin
          if (hold_i) begin
            state_q <= ST_HOLD;
          end else if (presc_tc) begin
            presc_q    <= '0;
            minutes_q  <= minutes_inc;
            min_tick_q <= 1'b1;
`ifdef GAME_MINUTE_CLOCK_BCD_EN
            bcd_q      <= bcd_inc(bcd_q);
`endif
            if (minutes_inc == MAX_MIN) begin
              state_q <= ST_SAT;
            end
          end else begin
            presc_q <= presc_q + PRE_W'(1);
          end
        end
        ST_HOLD: begin
          if (!hold_i) begin
            state_q <= ST_RUN;
          end
        end
        ST_SAT: begin
          minutes_q <= MAX_MIN;
        end
        default: begin
          state_q <= ST_STOP;
        end
      endcase

      if (arm_i) begin
        deadline_q <= deadline_d;
        armed_q    <= 1'b1;
      end else if (disarm_i) begin
        armed_q <= 1'b0;
      end
    end
  end

  assign minutes_o      = minutes_q;
  assign min_tick_o     = min_tick_q;
  assign running_o      = (state_q == ST_RUN);
  assign saturated_o    = (state_q == ST_SAT);
  assign deadline_hit_o = armed_q && (minutes_q >= deadline_q);

`ifdef GAME_MINUTE_CLOCK_BCD_EN
  assign minutes_bcd_o = bcd_q;
`endif

endmodule

// File: tb/tb_game_minute_clock.sv
// Self-checking bench for game_minute_clock with TICKS_PER_MIN=4, MAX_MIN=10, QUIZ_WIN=3.
// Each driven cycle pushes its expected outputs to a scoreboard queue, popped after the edge.
module tb_game_minute_clock;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic       clear_i;
  logic       hold_i;
  logic       arm_i;
  logic       disarm_i;
  logic [7:0] minutes_o;
  logic       min_tick_o;
  logic       running_o;
  logic       saturated_o;
  logic       deadline_hit_o;
`ifdef GAME_MINUTE_CLOCK_BCD_EN
  logic [11:0] minutes_bcd_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start;
    logic       clear;
    logic       hold;
    logic       arm;
    logic       disarm;
    logic [7:0] expMin;
    logic       expTick;
    logic       expRun;
    logic       expSat;
    logic       expHit;
  } vec_t;

  vec_t expQ[$];
  vec_t table6[17];

  game_minute_clock #(
    .TICKS_PER_MIN(4),
    .MAX_MIN      (8'd10),
    .QUIZ_WIN     (8'd3)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start_i),
    .clear_i       (clear_i),
    .hold_i        (hold_i),
    .arm_i         (arm_i),
    .disarm_i      (disarm_i),
    .minutes_o     (minutes_o),
    .min_tick_o    (min_tick_o),
    .running_o     (running_o),
    .saturated_o   (saturated_o),
    .deadline_hit_o(deadline_hit_o)
`ifdef GAME_MINUTE_CLOCK_BCD_EN
    ,
    .minutes_bcd_o (minutes_bcd_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic s, input logic c, input logic h, input logic a,
                                 input logic d, input logic [7:0] m, input logic t,
                                 input logic r, input logic sat, input logic hit);
    vec_t v;
    v.start = s; v.clear = c; v.hold = h; v.arm = a; v.disarm = d;
    v.expMin = m; v.expTick = t; v.expRun = r; v.expSat = sat; v.expHit = hit;
    return v;
  endfunction

  task automatic checkOutput(input string label);
    vec_t e;
    logic [11:0] act;
    logic [11:0] req;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty", label);
      return;
    end
    e = expQ.pop_front();
    act = {minutes_o, min_tick_o, running_o, saturated_o, deadline_hit_o};
    req = {e.expMin, e.expTick, e.expRun, e.expSat, e.expHit};
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got min=%0d tick=%b run=%b sat=%b hit=%b, want min=%0d tick=%b run=%b sat=%b hit=%b",
               label, minutes_o, min_tick_o, running_o, saturated_o, deadline_hit_o,
               e.expMin, e.expTick, e.expRun, e.expSat, e.expHit);
    end
`ifdef GAME_MINUTE_CLOCK_BCD_EN
    begin
      logic [11:0] bcdExp;
      bcdExp = {4'(e.expMin / 100), 4'((e.expMin / 10) % 10), 4'(e.expMin % 10)};
      checks++;
      if (minutes_bcd_o !== bcdExp) begin
        errors++;
        $display("[TB] FAIL %s_bcd: got %h want %h", label, minutes_bcd_o, bcdExp);
      end
    end
`endif
  endtask

  task automatic applyStimulus(input vec_t v, input string label);
    start_i  = v.start;
    clear_i  = v.clear;
    hold_i   = v.hold;
    arm_i    = v.arm;
    disarm_i = v.disarm;
    expQ.push_back(v);
    @(posedge clk);
    #1;
    checkOutput(label);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not end in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tickCount;
    int m;

    // Table for Arm-in-STOP, Arm+Disarm priority and Clear+Start priority.
    table6[0]  = mkVec(0,0,0,1,1, 8'd0, 0,0,0,0);
    table6[1]  = mkVec(1,0,0,0,0, 8'd0, 0,1,0,0);
    table6[2]  = mkVec(0,0,0,0,0, 8'd0, 0,1,0,0);
    table6[3]  = mkVec(0,0,0,0,0, 8'd0, 0,1,0,0);
    table6[4]  = mkVec(0,0,0,0,0, 8'd0, 0,1,0,0);
    table6[5]  = mkVec(0,0,0,0,0, 8'd1, 1,1,0,0);
    table6[6]  = mkVec(0,0,0,0,0, 8'd1, 0,1,0,0);
    table6[7]  = mkVec(0,0,0,0,0, 8'd1, 0,1,0,0);
    table6[8]  = mkVec(0,0,0,0,0, 8'd1, 0,1,0,0);
    table6[9]  = mkVec(0,0,0,0,0, 8'd2, 1,1,0,0);
    table6[10] = mkVec(0,0,0,0,0, 8'd2, 0,1,0,0);
    table6[11] = mkVec(0,0,0,0,0, 8'd2, 0,1,0,0);
    table6[12] = mkVec(0,0,0,0,0, 8'd2, 0,1,0,0);
    table6[13] = mkVec(0,0,0,0,0, 8'd3, 1,1,0,1);
    table6[14] = mkVec(0,0,0,0,1, 8'd3, 0,1,0,0);
    table6[15] = mkVec(1,1,0,0,0, 8'd0, 0,0,0,0);
    table6[16] = mkVec(0,0,0,0,0, 8'd0, 0,0,0,0);

    rst_n = 1'b0; start_i = 0; clear_i = 0; hold_i = 0; arm_i = 0; disarm_i = 0;
    #12;
    rst_n = 1'b1;

    // Test 1: run to 5 minutes, then assert reset asynchronously mid-cycle.
    applyStimulus(mkVec(1,0,0,0,0, 8'd0, 0,1,0,0), "t1_start");
    for (int i = 1; i <= 20; i++)
      applyStimulus(mkVec(0,0,0,0,0, 8'(i / 4), (i % 4) == 0, 1,0,0), "t1_run");
    #3;
    rst_n = 1'b0;
    #1;
    expQ.push_back(mkVec(0,0,0,0,0, 8'd0, 0,0,0,0));
    checkOutput("t1_async_reset");
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++)
      applyStimulus(mkVec(0,0,0,0,0, 8'd0, 0,0,0,0), "t1_idle_stop");

    // Test 2: twelve running cycles give three evenly spaced ticks.
    applyStimulus(mkVec(1,0,0,0,0, 8'd0, 0,1,0,0), "t2_start");
    tickCount = 0;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(mkVec(0,0,0,0,0, 8'(i / 4), (i % 4) == 0, 1,0,0), "t2_run");
      if (min_tick_o === 1'b1) tickCount++;
    end
    checks++;
    if (tickCount != 3) begin
      errors++;
      $display("[TB] FAIL t2_tick_count: got %0d want 3", tickCount);
    end

    // Test 3: hold on the terminal-count cycle, then release.
    for (int i = 13; i <= 15; i++)
      applyStimulus(mkVec(0,0,0,0,0, 8'd3, 0,1,0,0), "t3_pre");
    for (int i = 0; i < 7; i++)
      applyStimulus(mkVec(0,0,1,0,0, 8'd3, 0,0,0,0), "t3_hold");
    applyStimulus(mkVec(0,0,0,0,0, 8'd3, 0,1,0,0), "t3_release");
    applyStimulus(mkVec(0,0,0,0,0, 8'd4, 1,1,0,0), "t3_resume_inc");

    // Test 4: run into saturation, hold is ignored there, then clear.
    for (int j = 1; j <= 24; j++)
      applyStimulus(mkVec(0,0,0,0,0, 8'(4 + j / 4), (j % 4) == 0, j < 24, j == 24, 0), "t4_run");
    for (int j = 0; j < 20; j++)
      applyStimulus(mkVec(0,0,(j % 3) == 0,0,0, 8'd10, 0,0,1,0), "t4_sat");
    applyStimulus(mkVec(0,1,0,0,0, 8'd0, 0,0,0,0), "t4_clear");

    // Test 5: arm at 2 (deadline 5), re-arm at 9 (clamped to 10), disarm.
    applyStimulus(mkVec(1,0,0,0,0, 8'd0, 0,1,0,0), "t5_start");
    for (int j = 1; j <= 36; j++) begin
      m = j / 4;
      applyStimulus(mkVec(0,0,0,j == 9,0, 8'(m), (j % 4) == 0, 1,0, (j >= 9) && (m >= 5)), "t5_arm2");
    end
    for (int j = 37; j <= 40; j++) begin
      m = j / 4;
      applyStimulus(mkVec(0,0,0,j == 37,0, 8'(m), (j % 4) == 0, j < 40, j == 40, m >= 10), "t5_arm9");
    end
    applyStimulus(mkVec(0,0,0,0,1, 8'd10, 0,0,1,0), "t5_disarm");
    applyStimulus(mkVec(0,1,0,0,0, 8'd0, 0,0,0,0), "t5_clear");

    // Test 6: table-driven priorities from STOP.
    for (int k = 0; k < 17; k++)
      applyStimulus(table6[k], $sformatf("t6_vec%0d", k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
